// File: rtl/wb_stage.sv
// ---------------------------------------------------------------------------
// wb_stage -- pipeline write-back stage
//
// Holds the MEM/WB pipeline register, chooses memory data or ALU data as the
// write-back value, and commits that value to a small register file. Decode
// reads the file through two combinational ports that bypass the pending
// write. Execute gets a forwarding tap. A free-running counter records the
// number of retired instructions.
//
// Ports
//   clock, reset         rising-edge clock, synchronous active-high reset
//   in_valid, stall      MEM holds an instruction / MEM is not advancing
//   Wr_MEM, Rm_MEM       instruction writes a register / loads from memory
//   rdmem                destination register index
//   acOutWb, data_out    ALU result and memory read data
//   ra_addr, rb_addr     decode read indices
//   ra_data, rb_data     bypassed read data
//   fwd_valid/rd/value   write pending in WB (index/value are zero when idle)
//   retired              retired-instruction count, wraps on overflow
// ---------------------------------------------------------------------------
module wb_stage #(
  parameter int DATA_W = 8,
  parameter int RD_W   = 2,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              stall,
  input  logic              Wr_MEM,
  input  logic              Rm_MEM,
  input  logic [RD_W-1:0]   rdmem,
  input  logic [DATA_W-1:0] acOutWb,
  input  logic [DATA_W-1:0] data_out,
  input  logic [RD_W-1:0]   ra_addr,
  input  logic [RD_W-1:0]   rb_addr,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data,
  output logic              fwd_valid,
  output logic [RD_W-1:0]   fwd_rd,
  output logic [DATA_W-1:0] fwd_value,
  output logic [CNT_W-1:0]  retired
);

  localparam int NREGS = 1 << RD_W;

  logic              wb_valid_q, wb_valid_d;
  logic              wb_wr_q,    wb_wr_d;
  logic [RD_W-1:0]   wb_rd_q,    wb_rd_d;
  logic [DATA_W-1:0] wb_value_q, wb_value_d;
  logic [CNT_W-1:0]  retired_q,  retired_d;
  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic              wb_write;

  assign wb_write = wb_valid_q & wb_wr_q;

  // Next-state: MEM/WB capture, register-file commit, retire count
  always_comb begin
    // A stalled MEM stage or an empty slot both become a bubble in WB.
    wb_valid_d = in_valid & ~stall;
    wb_wr_d    = Wr_MEM;
    wb_rd_d    = rdmem;
    wb_value_d = Rm_MEM ? data_out : acOutWb;

    for (int i = 0; i < NREGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (wb_write) begin
      regs_d[wb_rd_q] = wb_value_q;
    end

    retired_d = retired_q;
    if (wb_valid_q) begin
      retired_d = retired_q + CNT_W'(1);
    end
  end

  // MEM/WB boundary; reset also discards any write still sitting in WB
  always_ff @(posedge clock) begin
    if (reset) begin
      wb_valid_q <= 1'b0;
      wb_wr_q    <= 1'b0;
      wb_rd_q    <= '0;
      wb_value_q <= '0;
      retired_q  <= '0;
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_wr_q    <= wb_wr_d;
      wb_rd_q    <= wb_rd_d;
      wb_value_q <= wb_value_d;
      retired_q  <= retired_d;
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Read ports: the pending write in WB is younger than the array contents,
  // so it wins whenever the index matches.
  always_comb begin
    ra_data = regs_q[ra_addr];
    rb_data = regs_q[rb_addr];
    if (wb_write && (ra_addr == wb_rd_q)) begin
      ra_data = wb_value_q;
    end
    if (wb_write && (rb_addr == wb_rd_q)) begin
      rb_data = wb_value_q;
    end
  end

  assign fwd_valid = wb_write;
  assign fwd_rd    = wb_write ? wb_rd_q    : '0;
  assign fwd_value = wb_write ? wb_value_q : '0;
  assign retired   = retired_q;

endmodule

// File: tb/tb_wb_stage.sv
// ---------------------------------------------------------------------------
// tb_wb_stage -- scoreboard bench for wb_stage.
// The stimulus process drives one cycle of inputs shortly after each rising
// edge and queues the outputs expected in that same cycle. A monitor pops the
// queue on each falling edge and compares every output field.
// ---------------------------------------------------------------------------
module tb_wb_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        stall = 1'b0;
  logic        Wr_MEM = 1'b0;
  logic        Rm_MEM = 1'b0;
  logic [1:0]  rdmem = '0;
  logic [7:0]  acOutWb = '0;
  logic [7:0]  data_out = '0;
  logic [1:0]  ra_addr = '0;
  logic [1:0]  rb_addr = '0;
  logic [7:0]  ra_data;
  logic [7:0]  rb_data;
  logic        fwd_valid;
  logic [1:0]  fwd_rd;
  logic [7:0]  fwd_value;
  logic [15:0] retired;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       tag;
    logic [7:0]  ra;
    logic [7:0]  rb;
    logic        fv;
    logic [1:0]  frd;
    logic [7:0]  fval;
    logic [15:0] ret;
  } exp_t;

  exp_t exp_q[$];

  wb_stage #(.DATA_W(8), .RD_W(2), .CNT_W(16)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .stall     (stall),
    .Wr_MEM    (Wr_MEM),
    .Rm_MEM    (Rm_MEM),
    .rdmem     (rdmem),
    .acOutWb   (acOutWb),
    .data_out  (data_out),
    .ra_addr   (ra_addr),
    .rb_addr   (rb_addr),
    .ra_data   (ra_data),
    .rb_data   (rb_data),
    .fwd_valid (fwd_valid),
    .fwd_rd    (fwd_rd),
    .fwd_value (fwd_value),
    .retired   (retired)
  );

  always #5 clock = ~clock;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: one expectation per observed cycle.
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      cmp({e.tag, ".ra_data"},   32'(ra_data),   32'(e.ra));
      cmp({e.tag, ".rb_data"},   32'(rb_data),   32'(e.rb));
      cmp({e.tag, ".fwd_valid"}, 32'(fwd_valid), 32'(e.fv));
      cmp({e.tag, ".fwd_rd"},    32'(fwd_rd),    32'(e.frd));
      cmp({e.tag, ".fwd_value"}, 32'(fwd_value), 32'(e.fval));
      cmp({e.tag, ".retired"},   32'(retired),   32'(e.ret));
    end
  end

  // One cycle: drive MEM-side and read inputs, optionally queue the outputs
  // expected during this cycle.
  task automatic step(input string tag, input int rs, input int v, input int st,
                      input int wr, input int rm, input int rd, input int ac,
                      input int dout, input int a, input int b, input int chk,
                      input int era, input int erb, input int efv, input int efrd,
                      input int efval, input int eret);
    exp_t e;
    @(posedge clock);
    #1;
    reset    = rs[0];
    in_valid = v[0];
    stall    = st[0];
    Wr_MEM   = wr[0];
    Rm_MEM   = rm[0];
    rdmem    = 2'(rd);
    acOutWb  = 8'(ac);
    data_out = 8'(dout);
    ra_addr  = 2'(a);
    rb_addr  = 2'(b);
    if (chk != 0) begin
      e.tag  = tag;
      e.ra   = 8'(era);
      e.rb   = 8'(erb);
      e.fv   = efv[0];
      e.frd  = 2'(efrd);
      e.fval = 8'(efval);
      e.ret  = 16'(eret);
      exp_q.push_back(e);
    end
  endtask

  initial begin
    //        tag         rs v st wr rm rd ac    dout  a  b chk  ra    rb    fv frd fval  ret
    step("rst0",      1, 0, 0, 0, 0, 0, 0,    0,    2, 3, 0,   0,    0,    0, 0, 0,    0);
    step("rst1",      1, 0, 0, 0, 0, 0, 0,    0,    2, 3, 1,   0,    0,    0, 0, 0,    0);
    step("idle",      0, 0, 0, 0, 0, 0, 0,    0,    2, 3, 1,   0,    0,    0, 0, 0,    0);
    // ALU write r1=5A: bypass in T1, array in T2
    step("w5a_t0",    0, 1, 0, 1, 0, 1, 'h5A, 0,    1, 0, 1,   0,    0,    0, 0, 0,    0);
    step("w5a_t1",    0, 0, 0, 0, 0, 0, 0,    0,    1, 1, 1,   'h5A, 'h5A, 1, 1, 'h5A, 0);
    step("w5a_t2",    0, 0, 0, 0, 0, 0, 0,    0,    1, 2, 1,   'h5A, 0,    0, 0, 0,    1);
    // Load selects memory data
    step("ld_t0",     0, 1, 0, 1, 1, 2, 'h10, 'hC3, 2, 1, 1,   0,    'h5A, 0, 0, 0,    1);
    step("ld_t1",     0, 0, 0, 0, 0, 0, 0,    0,    2, 0, 1,   'hC3, 0,    1, 2, 'hC3, 1);
    step("ld_t2",     0, 0, 0, 0, 0, 0, 0,    0,    2, 3, 1,   'hC3, 0,    0, 0, 0,    2);
    // Stall and in_valid=0 both produce bubbles
    step("stl_t0",    0, 1, 1, 1, 0, 3, 'hFF, 0,    3, 1, 1,   0,    'h5A, 0, 0, 0,    2);
    step("stl_t1",    0, 0, 0, 0, 0, 0, 0,    0,    3, 2, 1,   0,    'hC3, 0, 0, 0,    2);
    step("stl_t2",    0, 0, 0, 0, 0, 0, 0,    0,    3, 3, 1,   0,    0,    0, 0, 0,    2);
    step("nv_t0",     0, 0, 0, 1, 0, 3, 'hEE, 0,    3, 0, 1,   0,    0,    0, 0, 0,    2);
    step("nv_t1",     0, 0, 0, 0, 0, 0, 0,    0,    3, 0, 1,   0,    0,    0, 0, 0,    2);
    step("nv_t2",     0, 0, 0, 0, 0, 0, 0,    0,    3, 0, 1,   0,    0,    0, 0, 0,    2);
    // Back-to-back writes to r1: younger value wins on the ports
    step("b2b_t0",    0, 1, 0, 1, 0, 1, 'h11, 0,    1, 0, 1,   'h5A, 0,    0, 0, 0,    2);
    step("b2b_t1",    0, 1, 0, 1, 0, 1, 'h22, 0,    1, 1, 1,   'h11, 'h11, 1, 1, 'h11, 2);
    step("b2b_t2",    0, 0, 0, 0, 0, 0, 0,    0,    1, 0, 1,   'h22, 0,    1, 1, 'h22, 3);
    step("b2b_t3",    0, 0, 0, 0, 0, 0, 0,    0,    1, 0, 1,   'h22, 0,    0, 0, 0,    4);
    // Store-like: retires without a register write
    step("st_t0",     0, 1, 0, 0, 1, 2, 0,    'h99, 2, 0, 1,   'hC3, 0,    0, 0, 0,    4);
    step("st_t1",     0, 0, 0, 0, 0, 0, 0,    0,    2, 0, 1,   'hC3, 0,    0, 0, 0,    4);
    step("st_t2",     0, 0, 0, 0, 0, 0, 0,    0,    2, 0, 1,   'hC3, 0,    0, 0, 0,    5);
    // Pending write to r0 discarded by reset
    step("r0_t0",     0, 1, 0, 1, 0, 0, 'h77, 0,    0, 0, 1,   0,    0,    0, 0, 0,    5);
    step("r0_t1",     1, 0, 0, 0, 0, 0, 0,    0,    0, 0, 1,   'h77, 'h77, 1, 0, 'h77, 5);
    step("r0_t2",     0, 0, 0, 0, 0, 0, 0,    0,    0, 0, 1,   0,    0,    0, 0, 0,    0);
    step("r0_t3",     0, 0, 0, 0, 0, 0, 0,    0,    0, 0, 1,   0,    0,    0, 0, 0,    0);
    // Counter wrap: 65535 retiring cycles, then one more
    for (int i = 0; i < 65535; i++) begin
      step("wrap_run", 0, 1, 0, 0, 0, 0, 0,   0,    0, 0, 0,   0,    0,    0, 0, 0,    0);
    end
    step("wrap_a",    0, 1, 0, 0, 0, 0, 0,    0,    0, 0, 1,   0,    0,    0, 0, 0,    'hFFFE);
    step("wrap_b",    0, 0, 0, 0, 0, 0, 0,    0,    0, 0, 1,   0,    0,    0, 0, 0,    'hFFFF);
    step("wrap_c",    0, 0, 0, 0, 0, 0, 0,    0,    0, 0, 1,   0,    0,    0, 0, 0,    0);
    step("wrap_d",    0, 0, 0, 0, 0, 0, 0,    0,    0, 0, 1,   0,    0,    0, 0, 0,    0);

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) begin
      @(negedge clock);
      #1;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
